// File: rtl/sid_pkg.sv
// Shared SID register-bus definitions: bus widths, register map and the host
// command record used by the register writer and its command FIFO.
package sid_pkg;

    localparam int SID_ADDR_W = 5;
    localparam int SID_DATA_W = 8;

    localparam logic [SID_ADDR_W-1:0] SID_LAST_WR_ADDR = 5'h18;
    localparam int                    SID_NUM_WR_REGS  = 25;

    localparam logic [SID_ADDR_W-1:0] SID_VOICE1_BASE = 5'h00;
    localparam logic [SID_ADDR_W-1:0] SID_VOICE2_BASE = 5'h07;
    localparam logic [SID_ADDR_W-1:0] SID_VOICE3_BASE = 5'h0E;
    localparam logic [SID_ADDR_W-1:0] SID_FC_LO       = 5'h15;
    localparam logic [SID_ADDR_W-1:0] SID_FC_HI       = 5'h16;
    localparam logic [SID_ADDR_W-1:0] SID_RES_FILT    = 5'h17;
    localparam logic [SID_ADDR_W-1:0] SID_MODE_VOL    = 5'h18;

    typedef struct packed {
        logic [SID_ADDR_W-1:0] addr;
        logic [SID_DATA_W-1:0] data;
    } sid_cmd_t;

    // 0x19..0x1F are the chip's read-only registers (pots, OSC3, ENV3).
    function automatic logic sid_addr_writable(input logic [SID_ADDR_W-1:0] addr);
        return addr <= SID_LAST_WR_ADDR;
    endfunction

endpackage

// File: rtl/sid_cmd_fifo.sv
// Synchronous command FIFO. Occupancy is kept in its own counter rather than
// derived from the pointers, so full and empty are unambiguous at any depth.
module sid_cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 13
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               pop_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          push_ok, pop_ok;

    assign full     = (level_q == LW'(DEPTH));
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign push_ok  = push & ~full;
    assign pop_ok   = pop & ~empty;

    // Pointers are exactly log2(DEPTH) wide, so increments wrap modulo DEPTH.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/sid_reg_writer.sv
// SID register-bus initiator: queues host writes and replays them on WR/ADDR/DATA,
// one per CLKen tick at most. Define SID_REG_SHADOW_EN for the readable shadow file.
module sid_reg_writer
    import sid_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int MIN_GAP    = 1
) (
    input  logic                        CLK,
    input  logic                        RSTn,
    input  logic                        CLKen,
    input  logic                        IN_VALID,
    output logic                        IN_READY,
    input  logic [SID_ADDR_W-1:0]       IN_ADDR,
    input  logic [SID_DATA_W-1:0]       IN_DATA,
    output logic                        WR,
    output logic [SID_ADDR_W-1:0]       ADDR,
    output logic [SID_DATA_W-1:0]       DATA,
    output logic                        BUSY,
    output logic [$clog2(FIFO_DEPTH):0] LEVEL,
    output logic                        DROPPED,
    input  logic [SID_ADDR_W-1:0]       RD_ADDR,
    output logic [SID_DATA_W-1:0]       RD_DATA
);

    logic [1:0]            rst_sync_q, rst_sync_d;
    logic [3:0]            gap_q, gap_d;
    logic                  wr_q, wr_d;
    logic                  dropped_q, dropped_d;
    logic [SID_ADDR_W-1:0] addr_q, addr_d;
    logic [SID_DATA_W-1:0] data_q, data_d;
    sid_cmd_t              head;
    logic                  fifo_full, fifo_empty;
    logic                  push, issue, head_wr;

    // Host handshake: a command transfers on a CLK edge where IN_VALID and
    // IN_READY are both high; IN_READY comes only from registered state.
    assign IN_READY = rst_sync_q[1] & ~fifo_full;
    assign push     = IN_VALID & IN_READY;
    assign issue    = CLKen & ~fifo_empty & (gap_q == '0);
    assign head_wr  = sid_addr_writable(head.addr);

    sid_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(sid_cmd_t))
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (RSTn),
        .push      (push),
        .push_data ({IN_ADDR, IN_DATA}),
        .pop       (issue),
        .pop_data  (head),
        .level     (LEVEL),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Read-only commands are consumed like writes (including the gap) but only pulse DROPPED.
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
        gap_d      = gap_q;
        wr_d       = 1'b0;
        dropped_d  = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        if (issue) begin
            gap_d = 4'(MIN_GAP - 1);
            if (head_wr) begin
                wr_d   = 1'b1;
                addr_d = head.addr;
                data_d = head.data;
            end else begin
                dropped_d = 1'b1;
            end
        end else if (CLKen && (gap_q != '0)) begin
            gap_d = gap_q - 4'd1;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rst_sync_q <= '0;
            gap_q      <= '0;
            wr_q       <= 1'b0;
            dropped_q  <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            rst_sync_q <= rst_sync_d;
            gap_q      <= gap_d;
            wr_q       <= wr_d;
            dropped_q  <= dropped_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    assign WR      = wr_q;
    assign ADDR    = addr_q;
    assign DATA    = data_q;
    assign DROPPED = dropped_q;
    assign BUSY    = (LEVEL != '0) | wr_q;

`ifdef SID_REG_SHADOW_EN
    logic [SID_DATA_W-1:0] shadow_q [SID_NUM_WR_REGS];
    logic [SID_DATA_W-1:0] shadow_d [SID_NUM_WR_REGS];
    logic [SID_DATA_W-1:0] rd_data_q, rd_data_d;

    always_comb begin
        shadow_d = shadow_q;
        if (wr_d) begin
            shadow_d[head.addr] = head.data;
        end
        rd_data_d = (RD_ADDR <= SID_LAST_WR_ADDR) ? shadow_q[RD_ADDR] : '0;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < SID_NUM_WR_REGS; i++) begin
                shadow_q[i] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            shadow_q  <= shadow_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign RD_DATA = rd_data_q;
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^RD_ADDR;
    assign RD_DATA        = '0;
`endif

endmodule

// File: tb/tb_sid_reg_writer.sv
// Directed bench for sid_reg_writer (FIFO_DEPTH=8, MIN_GAP=3) with a write scoreboard.
module tb_sid_reg_writer;

  localparam int DEPTH = 8;
  localparam int GAP   = 3;

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic       CLKen = 1'b0;
  logic       IN_VALID = 1'b0;
  logic [4:0] IN_ADDR = '0;
  logic [7:0] IN_DATA = '0;
  logic [4:0] RD_ADDR = '0;
  logic       IN_READY, WR, BUSY, DROPPED;
  logic [4:0] ADDR;
  logic [7:0] DATA, RD_DATA;
  logic [3:0] LEVEL;

  int checks = 0;
  int failures = 0;
  logic [12:0] exp_q[$];
  int wr_ticks[$];
  int tick_cnt = 0;
  int drop_seen = 0;
  int exp_drop = 0;
  logic wr_prev = 1'b0;

  sid_reg_writer #(.FIFO_DEPTH(DEPTH), .MIN_GAP(GAP)) dut (
    .CLK(CLK), .RSTn(RSTn), .CLKen(CLKen), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_ADDR(IN_ADDR), .IN_DATA(IN_DATA), .WR(WR), .ADDR(ADDR), .DATA(DATA),
    .BUSY(BUSY), .LEVEL(LEVEL), .DROPPED(DROPPED), .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA)
  );

  // clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard monitor: samples 1ns after each rising edge
  always @(posedge CLK) begin
    logic [12:0] e;
    #1;
    if (RSTn === 1'b1) begin
      if (WR === 1'b1) begin
        chk("wr_one_cycle", 32'(wr_prev), 32'd0);
        checks++;
        assert (exp_q.size() != 0) else begin
          failures++;
          $error("FAIL wr_unexpected observed=%0h expected=none", {ADDR, DATA});
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("wr_addr_data", 32'({ADDR, DATA}), 32'(e));
        end
        wr_ticks.push_back(tick_cnt);
      end
      if (DROPPED === 1'b1) drop_seen++;
    end
    if (CLKen === 1'b1) tick_cnt++;
    wr_prev = WR;
  end

  // driver tasks
  task automatic tick();
    @(negedge CLK); CLKen = 1'b1;
    @(negedge CLK); CLKen = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick();
      @(negedge CLK);
      @(negedge CLK);
    end
  endtask

  task automatic push_cmd(input logic [4:0] a, input logic [7:0] d);
    int n = 0;
    @(negedge CLK);
    IN_VALID = 1'b1; IN_ADDR = a; IN_DATA = d;
    while (IN_READY !== 1'b1 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("push_ready", 32'(IN_READY), 32'd1);
    if (IN_READY === 1'b1) begin
      if (a <= 5'h18) exp_q.push_back({a, d});
      else exp_drop++;
    end
  endtask

  task automatic idle_in();
    @(negedge CLK);
    IN_VALID = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (IN_READY !== 1'b1 && n < 10) begin
      @(negedge CLK);
      n++;
    end
    chk("ready_after_reset", 32'(IN_READY), 32'd1);
  endtask

  initial begin
    int base;
    int d0;
    int n;
    // reset state
    repeat (3) @(negedge CLK);
    chk("rst_wr", 32'(WR), 32'd0);
    chk("rst_addr", 32'(ADDR), 32'd0);
    chk("rst_data", 32'(DATA), 32'd0);
    chk("rst_dropped", 32'(DROPPED), 32'd0);
    chk("rst_level", 32'(LEVEL), 32'd0);
    chk("rst_in_ready", 32'(IN_READY), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_rd_data", 32'(RD_DATA), 32'd0);
    RSTn = 1'b1;
    wait_ready();

    // single write
    push_cmd(5'h01, 8'hA5);
    idle_in();
    chk("single_level1", 32'(LEVEL), 32'd1);
    chk("single_busy1", 32'(BUSY), 32'd1);
    chk("single_no_early_wr", 32'(WR), 32'd0);
    tick();
    chk("single_wr", 32'(WR), 32'd1);
    chk("single_addr", 32'(ADDR), 32'h01);
    chk("single_data", 32'(DATA), 32'hA5);
    chk("single_level0", 32'(LEVEL), 32'd0);
    @(negedge CLK);
    chk("single_wr_low", 32'(WR), 32'd0);
    chk("single_busy0", 32'(BUSY), 32'd0);
    chk("single_addr_hold", 32'(ADDR), 32'h01);
    ticks(4);

    // burst pacing
    base = wr_ticks.size();
    for (int i = 0; i < 4; i++) push_cmd(5'(2 + i), 8'($urandom_range(0, 255)));
    idle_in();
    ticks(16);
    chk("burst_count", 32'(wr_ticks.size() - base), 32'd4);
    if (wr_ticks.size() - base == 4)
      for (int i = 1; i < 4; i++)
        chk("burst_gap", 32'(wr_ticks[base + i] - wr_ticks[base + i - 1]), 32'(GAP));

    // full FIFO with CLKen held low
    for (int i = 0; i < DEPTH; i++)
      push_cmd(5'($urandom_range(0, 24)), 8'($urandom_range(0, 255)));
    @(negedge CLK);
    IN_ADDR = 5'h07; IN_DATA = 8'hEE;
    chk("full_level", 32'(LEVEL), 32'd8);
    chk("full_not_ready", 32'(IN_READY), 32'd0);
    @(negedge CLK);
    chk("full_no_overwrite", 32'(LEVEL), 32'd8);
    IN_VALID = 1'b0;
    base = wr_ticks.size();
    ticks(28);
    chk("full_drain_count", 32'(wr_ticks.size() - base), 32'd8);
    chk("full_drain_level", 32'(LEVEL), 32'd0);

    // read-only drop
    d0 = drop_seen;
    base = wr_ticks.size();
    push_cmd(5'h04, 8'h11);
    push_cmd(5'h1B, 8'h55);
    push_cmd(5'h05, 8'h22);
    idle_in();
    ticks(12);
    chk("drop_wr_count", 32'(wr_ticks.size() - base), 32'd2);
    chk("drop_pulses", 32'(drop_seen - d0), 32'd1);
    if (wr_ticks.size() - base == 2)
      chk("drop_keeps_gap", 32'(wr_ticks[base + 1] - wr_ticks[base]), 32'(2 * GAP));

    // reset mid-burst
    for (int i = 0; i < 5; i++) push_cmd(5'(8 + i), 8'(16 * i + 3));
    idle_in();
    n = 0;
    tick();
    while (WR !== 1'b1 && n < 10) begin
      @(negedge CLK); @(negedge CLK);
      tick();
      n++;
    end
    chk("pre_reset_wr", 32'(WR), 32'd1);
    RSTn = 1'b0;
    #1;
    chk("async_wr_fall", 32'(WR), 32'd0);
    chk("async_level0", 32'(LEVEL), 32'd0);
    chk("async_in_ready0", 32'(IN_READY), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    wait_ready();
    base = wr_ticks.size();
    ticks(6);
    chk("post_reset_no_wr", 32'(wr_ticks.size() - base), 32'd0);
    chk("post_reset_busy", 32'(BUSY), 32'd0);

    // shadow readback
    push_cmd(5'h18, 8'h0F);
    idle_in();
    ticks(2);
    @(negedge CLK); RD_ADDR = 5'h18;
    @(negedge CLK);
`ifdef SID_REG_SHADOW_EN
    chk("shadow_18", 32'(RD_DATA), 32'h0F);
`else
    chk("shadow_18", 32'(RD_DATA), 32'h00);
`endif
    RD_ADDR = 5'h1C;
    @(negedge CLK);
    chk("shadow_ro_addr", 32'(RD_DATA), 32'h00);
    RD_ADDR = 5'h01;
    @(negedge CLK);
    chk("shadow_cleared_by_reset", 32'(RD_DATA), 32'h00);

    // final report
    @(negedge CLK);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("drop_total", 32'(drop_seen), 32'(exp_drop));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sid_reg_writer.md
Name: sid_reg_writer

Overview:
- Bus initiator for the SID register interface: accepts host write commands (address/data) over a valid/ready handshake and buffers them in a small FIFO.
- Replays them onto the shared WR/ADDR/DATA register bus that every sid_voice and the filter/envelope blocks decode.
- Writes are paced to the 1 MHz CLKen tick, so the voice logic sees at most one register update per SID cycle, as on the real chip.
- Sits between the host/UART command decoder and the SID core.

Parameters:
- FIFO_DEPTH, 8, command FIFO entries; power of two, 2..64.
- MIN_GAP, 1, minimum CLKen ticks between successive issued writes; 1..15.

Ports:
- CLK  in  1  master clock
- RSTn  in  1  asynchronous active-low reset
- CLKen  in  1  1 MHz enable, one CLK cycle wide
- IN_VALID  in  1  host command valid
- IN_READY  out  1  FIFO can accept a command
- IN_ADDR  in  5  host register address
- IN_DATA  in  8  host register data
- WR  out  1  register bus write strobe, one CLK cycle wide
- ADDR  out  5  register bus address
- DATA  out  8  register bus data
- BUSY  out  1  FIFO non-empty or write in flight
- LEVEL  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- DROPPED  out  1  one-cycle pulse when a read-only address is discarded
- RD_ADDR  in  5  shadow read address
- RD_DATA  out  8  shadow read data

Behaviour:
- Reset (async, RSTn=0):
  - WR=0, ADDR=0, DATA=0, DROPPED=0.
  - FIFO empty, LEVEL=0, gap counter=0, IN_READY=0 while RSTn low.
  - Reset mid-operation discards all queued commands; a WR already high falls immediately.
- Push:
  - IN_READY = RSTn_synced & (LEVEL != FIFO_DEPTH). It depends only on registered state, never on same-cycle pop.
  - Command accepted on a CLK edge with IN_VALID & IN_READY.
- Issue (pop) condition, evaluated at a CLK edge: CLKen=1, FIFO non-empty, gap counter=0.
  - On issue: head popped; ADDR/DATA registered from head; WR=1 for exactly the next cycle, then 0.
  - ADDR/DATA hold their last value while WR=0.
- Issue latency:
  - Command pushed into an empty FIFO at edge N appears on WR at the first CLKen edge strictly after N, given gap=0.
  - Minimum latency is 1 CLK cycle, maximum 1 CLKen period.
- Read-only addresses:
  - IN_ADDR 0x19..0x1F are accepted and popped in order like any command, but are never issued. WR stays 0 and ADDR/DATA are unchanged.
  - DROPPED pulses for one cycle instead.
  - A dropped command still loads the gap counter.
- Gap counter:
  - Loads MIN_GAP-1 on each pop.
  - Decrements on each CLKen while non-zero.
  - With MIN_GAP=1, back-to-back writes land on consecutive CLKen ticks.
- Simultaneous push and pop: LEVEL unchanged; data order preserved. A push into an empty FIFO is not issuable on that same edge.
- Full FIFO: IN_READY=0; IN_VALID is ignored with no overwrite.
- Pointers: read and write pointers wrap modulo FIFO_DEPTH. LEVEL is a separate counter, never derived from the pointer difference.
- BUSY = (LEVEL != 0) | WR.
- CLKen: no assumption about CLKen phase relative to the host. CLKen held 0 stalls issue indefinitely; pushes continue until full.

Optional Feature:
- Macro: SID_REG_SHADOW_EN.
- Defined:
  - A 25x8 shadow register file (0x00..0x18) is updated on every issued write, not on dropped ones.
  - RD_DATA is registered and returns shadow[RD_ADDR] one cycle after RD_ADDR is presented.
  - RD_ADDR >= 0x19 returns 0x00.
  - Shadow resets to 0x00.
- Not defined: RD_DATA is constant 0x00, RD_ADDR is unused, and no shadow storage is inferred.

Decomposition:
- Shared package sid_pkg holds:
  - SID_ADDR_W=5, SID_DATA_W=8.
  - SID_LAST_WR_ADDR=5'h18 and SID_NUM_WR_REGS=25.
  - Register address constants (voice base 0x00/0x07/0x0E, FC_LO 0x15, FC_HI 0x16, RES_FILT 0x17, MODE_VOL 0x18).
  - A command struct typedef {addr, data}.
- One natural sub-module: sid_cmd_fifo, a parameterised synchronous FIFO with push/pop/level/full/empty and async active-low reset. The issue/gap/drop logic stays in the top.

Test Plan:
- Single write: push {0x01,0xA5} with FIFO empty, then CLKen pulse → exactly one WR cycle with ADDR=0x01, DATA=0xA5 the edge after CLKen; LEVEL 1→0; BUSY low afterwards.
- Burst and pacing: MIN_GAP=3, push 4 commands back-to-back → WR pulses on CLKen ticks t, t+3, t+6, t+9 in push order; IN_READY stays 1.
- Full FIFO: hold CLKen=0, push 9 commands at FIFO_DEPTH=8 → IN_READY falls after the 8th; the 9th is not accepted; LEVEL=8. Release CLKen → 8 writes in order.
- Read-only drop: push {0x1B,0x55} between {0x04,0x11} and {0x05,0x22} → WR for 0x04 and 0x05 only; DROPPED pulses once; ADDR never shows 0x1B.
- Reset mid-burst: 5 queued, RSTn low for 2 cycles coincident with WR=1 → WR drops asynchronously; LEVEL=0; no further WR after release without new pushes.
- Shadow (SID_REG_SHADOW_EN): write {0x18,0x0F}, then RD_ADDR=0x18 → RD_DATA=0x0F one cycle later; RD_ADDR=0x1C → 0x00.
